trig_seq_monitor: RTL
=====================

# trig_seq_monitor

Parametrised trigger monitor for the Trojan-detection subcircuit library. It registers a WIDTH-bit observed net vector through a DEPTH-stage flop pipeline and compares the oldest stage against a masked reference value. When THRESH consecutive enabled samples match, it asserts a trigger output, either sticky or as a one-cycle pulse. It replaces the fixed single-output DFF/gate trigger netlists with one configurable block that also keeps counters for the detection flow.

## Interface
- WIDTH, 4: bit width of the observed vector and of the reference/mask.
- DEPTH, 2: number of input register stages (≥1).
- THRESH, 3: consecutive matches required to fire (≥1).
- STICKY, 1: 1 = trig holds until clear or reset; 0 = trig is a one-cycle pulse.
- CNT_W, $clog2(THRESH+1): width of match_cnt.
- Clock/reset: one clock; reset is synchronous and active-low.
- I1470  input  1  clock; all state updates on the rising edge.
- I1477  input  1  synchronous active-low reset.
- clr  input  1  synchronous clear of FSM, match_cnt and trig; does not affect pipeline or fire_cnt.
- en  input  1  evaluation enable; the pipeline always shifts.
- data_in  input  WIDTH  observed net vector.
- match_val  input  WIDTH  reference value.
- match_mask  input  WIDTH  1 = bit compared, 0 = don't care.
- trig  output  1  trigger, registered.
- match_cnt  output  CNT_W  current consecutive-match count.
- fire_cnt  output  8  number of fires, saturating at 255.
- state  output  2  FSM state: 0 IDLE, 1 COUNT, 2 FIRED.

## Operation
- Pipeline: stage[0] <= data_in; stage[i] <= stage[i-1]. match = (((stage[DEPTH-1] ^ match_val) & match_mask) == 0). An all-zero mask always matches.
- Priority per edge: reset > clr > en == 0 (FSM, match_cnt and trig hold) > FSM evaluation.
- IDLE:
  - match → match_cnt = 1 and go to COUNT.
  - If THRESH == 1, go directly to FIRED instead.
  - No match → stay in IDLE, match_cnt = 0.
- COUNT:
  - match and match_cnt+1 == THRESH → FIRED, match_cnt = THRESH.
  - match otherwise → match_cnt + 1.
  - Mismatch → IDLE, match_cnt = 0.
- FIRED, STICKY = 1: trig = 1. Stays in FIRED regardless of match until clr or reset; match_cnt holds THRESH.
- FIRED, STICKY = 0: trig = 1 for exactly one cycle. Next enabled edge re-evaluates as IDLE, so a match gives match_cnt = 1 in COUNT (or FIRED again if THRESH = 1); a mismatch gives IDLE with match_cnt = 0.
- If en is low while in FIRED with STICKY = 0, trig and state hold until the next enabled edge.
- fire_cnt increments by 1 on every transition into FIRED, saturates at 255, and is cleared only by reset.
- state 3 is unreachable; if decoded, it returns to IDLE with match_cnt = 0 and trig = 0.

## Timing
- Reset values (edge with I1477 = 0): all stages 0, state IDLE, match_cnt 0, trig 0, fire_cnt 0. Reset applied mid-sequence or in FIRED takes effect at that edge with no residual pulse.
- Latency: if the first matching sample is captured at edge k and the following samples keep matching, trig is high after edge k+DEPTH+THRESH-1. Example with DEPTH = 2, THRESH = 3: k = 1 gives trig after edge 5.
- match is combinational from stage[DEPTH-1]. All outputs are registered with no combinational path from input to output.
- clr in the same cycle as the final match: clr wins; trig stays 0 and fire_cnt does not increment.
- en deasserted mid-count: the count is frozen, not reset. The pipeline keeps shifting, so the samples evaluated after re-enable are whatever is then at stage[DEPTH-1].

## Test plan
- Reset: hold I1477 = 0 for 2 cycles with random data_in → trig = 0, match_cnt = 0, fire_cnt = 0, state = 0, all stages 0.
- Fire (WIDTH = 4, DEPTH = 2, THRESH = 3, STICKY = 1): match_val = 4'hA, mask = 4'hF, data_in = A,A,A at edges 1–3 → trig rises after edge 5 and stays high; fire_cnt = 1; clr at edge 8 → trig = 0 and state IDLE after edge 8.
- Broken run: data_in = A,A,5,A,A,A → match_cnt goes 1, 2, 0, 1, 2, 3; trig rises only after the third consecutive A is evaluated.
- Pulse mode (STICKY = 0, THRESH = 1, mask = 4'h0): en = 1 for 10 cycles → trig pulses on each FIRED entry and fire_cnt increments each time; with en = 1 for 300 cycles, fire_cnt saturates at 255.
- Boundaries: en low for 4 cycles at match_cnt = 2 → count holds at 2. Reset asserted in FIRED → trig = 0 at that edge. clr coincident with the final match → no fire, fire_cnt unchanged.

Source files
------------

// File: rtl/trig_seq_monitor.sv
`default_nettype none
// trig_seq_monitor: pipelined masked-compare trigger; fires after THRESH consecutive matches.
// Revision: 1.0
module trig_seq_monitor #(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 2,
   parameter int THRESH = 3,
   parameter int STICKY = 1,
   parameter int CNT_W  = $clog2(THRESH + 1)
) (
   input  logic             I1470,
   input  logic             I1477,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] match_val,
   input  logic [WIDTH-1:0] match_mask,
   output logic             trig,
   output logic [CNT_W-1:0] match_cnt,
   output logic [7:0]       fire_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FIRED = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH);
   localparam logic [CNT_W:0]   THRESH_EXT = (CNT_W + 1)'(THRESH);

   logic [WIDTH-1:0] stage [DEPTH];
   logic             match;

   state_t           cur;
   state_t           nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W:0]   cnt_inc;
   logic             trig_nxt;
   logic             fire_inc;
   logic             evaluate;

   always_ff @(posedge I1470) begin
      if (!I1477) stage[0] <= '0;
      else        stage[0] <= data_in;
   end

   generate
      for (genvar i = 1; i < DEPTH; i++) begin : g_stage
         always_ff @(posedge I1470) begin
            if (!I1477) stage[i] <= '0;
            else        stage[i] <= stage[i-1];
         end
      end
   endgenerate

   assign match = (((stage[DEPTH-1] ^ match_val) & match_mask) == '0);

   // A pulse-mode FIRED state re-evaluates as if it were IDLE, so the run restarts at 1.
   assign cnt_inc = (cur == ST_COUNT) ? ({1'b0, match_cnt} + (CNT_W + 1)'(1))
                                      : (CNT_W + 1)'(1);

   always_comb begin
      nxt      = cur;
      cnt_nxt  = match_cnt;
      trig_nxt = trig;
      fire_inc = 1'b0;
      evaluate = 1'b0;
      if (clr) begin
         nxt      = ST_IDLE;
         cnt_nxt  = '0;
         trig_nxt = 1'b0;
      end else if (en) begin
         case (cur)
            ST_IDLE, ST_COUNT: evaluate = 1'b1;
            ST_FIRED:          evaluate = (STICKY == 0);
            default: begin
               nxt      = ST_IDLE;
               cnt_nxt  = '0;
               trig_nxt = 1'b0;
            end
         endcase
         if (evaluate) begin
            if (match && (cnt_inc >= THRESH_EXT)) begin
               nxt      = ST_FIRED;
               cnt_nxt  = THRESH_C;
               trig_nxt = 1'b1;
               fire_inc = 1'b1;
            end else if (match) begin
               nxt      = ST_COUNT;
               cnt_nxt  = cnt_inc[CNT_W-1:0];
               trig_nxt = 1'b0;
            end else begin
               nxt      = ST_IDLE;
               cnt_nxt  = '0;
               trig_nxt = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge I1470) begin
      if (!I1477) begin
         cur       <= ST_IDLE;
         match_cnt <= '0;
         trig      <= 1'b0;
         fire_cnt  <= 8'd0;
      end else begin
         cur       <= nxt;
         match_cnt <= cnt_nxt;
         trig      <= trig_nxt;
         if (fire_inc && (fire_cnt != 8'hFF))
            fire_cnt <= fire_cnt + 8'd1;
      end
   end

   assign state = cur;

endmodule
`default_nettype wire
